uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO, configurable data width and stop-bit count, and optional parity. An external bit-rate tick (clken, one clk_50m cycle wide, once per bit period) paces the serial line. Host logic pushes words with wr_en without polling tx_busy, and the block serialises them back-to-back, LSB first.

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 clken,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 tx_done,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;

  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bitcnt;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  // Full check uses the pre-pop count, so a full FIFO
  // rejects a write even if the FSM pops the same cycle.
  assign push = wr_en && (count < CW'(FIFO_DEPTH));
  assign pop  = (state == IDLE) && (count != '0);

  assign tx_busy    = (state != IDLE);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Storage array; contents need no reset.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && !push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; tx only moves on clken ticks.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      bitcnt  <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg  <= mem[rd_ptr];
            bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
            par    <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
`endif
            state  <= START;
          end
        end
        START: begin
          if (clken) begin
            tx    <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (clken) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            if (bitcnt == 4'(DATA_BITS - 1)) begin
              bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
`else
              state  <= STOP;
`endif
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (clken) begin
            tx    <= par;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (clken) begin
            tx <= 1'b1;
            if (bitcnt == 4'(STOP_BITS - 1)) begin
              bitcnt  <= '0;
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO and reset.
// Line is sampled once per clken tick and decoded afterwards.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n;
  logic       clken;
  logic       wr_en, wr7, wro;
  logic [7:0] din, dino;
  logic [6:0] din7;

  logic tx, busy, full, empty, done, ovf;
  logic tx7, busy7, full7, empty7, done7, ovf7;
  logic txo, busyo, fullo, emptyo, doneo, ovfo;

  uart_tx_fifo dut (
    .clk_50m(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
    .clken(clken), .tx(tx), .tx_busy(busy), .fifo_full(full),
    .fifo_empty(empty), .tx_done(done), .overflow(ovf)
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(2)) dut7 (
    .clk_50m(clk), .rst_n(rst_n), .din(din7), .wr_en(wr7),
    .clken(clken), .tx(tx7), .tx_busy(busy7), .fifo_full(full7),
    .fifo_empty(empty7), .tx_done(done7), .overflow(ovf7)
  );

  uart_tx_fifo #(.PARITY_ODD(1)) dut_o (
    .clk_50m(clk), .rst_n(rst_n), .din(dino), .wr_en(wro),
    .clken(clken), .tx(txo), .tx_busy(busyo), .fifo_full(fullo),
    .fifo_empty(emptyo), .tx_done(doneo), .overflow(ovfo)
  );

  int nchk = 0;
  int nerr = 0;
  int mode = 1;
  int div  = 0;
  int nd8 = 0, nd7 = 0, ndo = 0, novf = 0;

  bit s8[$], b8[$], s7[$], so[$];

  logic [8:0] rx_w[$];
  bit         rx_p[$];
  int         rx_g[$];
  int         rx_bad;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Tick generator plus per-tick line sampler and pulse counters.
  initial begin
    clken = 1'b0;
    forever begin
      @(negedge clk);
      if (clken) begin
        s8.push_back(tx);
        b8.push_back(busy);
        s7.push_back(tx7);
        so.push_back(txo);
      end
      if (done)  nd8++;
      if (done7) nd7++;
      if (doneo) ndo++;
      if (ovf)   novf++;
      case (mode)
        0: clken = 1'b0;
        2: clken = 1'b1;
        default: begin
          clken = (div == 3);
          div   = (div + 1) % 4;
        end
      endcase
    end
  end

  task automatic decode(input bit q[$], input int nb, input int sb);
    int i, g;
    logic [8:0] w;
    bit p;
    rx_w.delete(); rx_p.delete(); rx_g.delete();
    rx_bad = 0; i = 0; g = 0;
    while (i < q.size()) begin
      if (q[i]) begin
        g++; i++;
      end else if (i + nb + PE + sb >= q.size()) begin
        rx_bad++; i = q.size();
      end else begin
        w = '0;
        for (int k = 0; k < nb; k++) w[k] = q[i+1+k];
        p = (PE != 0) ? q[i+1+nb] : 1'b0;
        for (int k = 0; k < sb; k++)
          if (!q[i+1+nb+PE+k]) rx_bad++;
        rx_w.push_back(w); rx_p.push_back(p); rx_g.push_back(g);
        g = 0;
        i += 1 + nb + PE + sb;
      end
    end
  endtask

  task automatic wait_done(input int which, input int n);
    int t = 0;
    int c;
    c = (which == 0) ? nd8 : (which == 1) ? nd7 : ndo;
    while (c < n && t < 3000) begin
      @(negedge clk);
      t++;
      c = (which == 0) ? nd8 : (which == 1) ? nd7 : ndo;
    end
    if (c < n) chk("wait_done_timeout", c, n);
  endtask

  task automatic push8(input logic [7:0] d);
    din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int d, j, ones, zeros;
    logic [9:0] seq;
    logic [5:0] ovv;

    rst_n = 1'b0; wr_en = 1'b0; wr7 = 1'b0; wro = 1'b0;
    din = '0; din7 = '0; dino = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx7", tx7, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame: 0xA5 -> 0,1,0,1,0,0,1,0,1 then stop/parity.
    s8.delete(); b8.delete(); d = nd8;
    push8(8'hA5);
    wait_done(0, d + 1);
    repeat (8) @(negedge clk);
    j = 0;
    while (j < s8.size() && s8[j]) j++;
    seq = '0;
    for (int k = 0; k < 10; k++)
      if (j + k < s8.size()) seq[k] = s8[j+k];
`ifdef UART_TX_PARITY_EN
    chk("a5_seq", seq, 10'b0101001010);
`else
    chk("a5_seq", seq, 10'b1101001010);
`endif
    ones = 0;
    for (int k = 0; k <= 8 + PE; k++)
      if (j + k < b8.size() && b8[j+k]) ones++;
    chk("a5_busy", ones, 9 + PE);
    chk("a5_done", nd8 - d, 1);

    // Three queued words go out back to back.
    s8.delete(); d = nd8;
    push8(8'h55); push8(8'h0F); push8(8'hF0);
    chk("b2b_nonempty", empty, 0);
    wait_done(0, d + 1);
    chk("b2b_q_after1", empty, 0);
    wait_done(0, d + 2);
    repeat (2) @(negedge clk);
    chk("b2b_empty_after3pop", empty, 1);
    chk("b2b_busy3", busy, 1);
    wait_done(0, d + 3);
    repeat (8) @(negedge clk);
    decode(s8, 8, 1);
    chk("b2b_nframes", rx_w.size(), 3);
    if (rx_w.size() == 3) begin
      chk("b2b_w0", rx_w[0], 9'h55);
      chk("b2b_w1", rx_w[1], 9'h0F);
      chk("b2b_w2", rx_w[2], 9'hF0);
      chk("b2b_gap1", rx_g[1], 0);
      chk("b2b_gap2", rx_g[2], 0);
    end
    chk("b2b_bad", rx_bad, 0);
    chk("b2b_done", nd8 - d, 3);

    // Ticks stopped: first word parks in the shifter, then the
    // FIFO takes four more and drops writes five and six.
    mode = 0;
    repeat (3) @(negedge clk);
    s8.delete(); d = nd8; j = novf;
    push8(8'h99);
    repeat (3) @(negedge clk);
    chk("hold_busy", busy, 1);
    chk("hold_tx_idle", tx, 1);
    chk("hold_empty", empty, 1);
    ovv = '0;
    for (int k = 0; k < 6; k++) begin
      push8(8'h11 * (k + 1));
      ovv[k] = ovf;
    end
    chk("ovf_pattern", ovv, 6'b110000);
    chk("ovf_count", novf - j, 2);
    chk("fifo_full", full, 1);
    chk("fifo_not_empty", empty, 0);
    mode = 1;
    wait_done(0, d + 5);
    repeat (8) @(negedge clk);
    decode(s8, 8, 1);
    chk("drain_nframes", rx_w.size(), 5);
    if (rx_w.size() == 5) begin
      chk("drain_w0", rx_w[0], 9'h99);
      chk("drain_w1", rx_w[1], 9'h11);
      chk("drain_w2", rx_w[2], 9'h22);
      chk("drain_w3", rx_w[3], 9'h33);
      chk("drain_w4", rx_w[4], 9'h44);
    end
    chk("drain_full", full, 0);
    chk("drain_empty", empty, 1);

    // Parity: 0x07 has three ones.
    s8.delete(); so.delete(); d = nd8; j = ndo;
    din = 8'h07; dino = 8'h07; wr_en = 1'b1; wro = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; wro = 1'b0;
    wait_done(0, d + 1);
    wait_done(2, j + 1);
    repeat (8) @(negedge clk);
    decode(s8, 8, 1);
    chk("par_even_n", rx_w.size(), 1);
    if (rx_w.size() == 1) begin
      chk("par_even_w", rx_w[0], 9'h07);
      if (PE != 0) chk("par_even_bit", rx_p[0], 1);
    end
    decode(so, 8, 1);
    chk("par_odd_n", rx_w.size(), 1);
    if (rx_w.size() == 1) begin
      chk("par_odd_w", rx_w[0], 9'h07);
      if (PE != 0) chk("par_odd_bit", rx_p[0], 0);
    end

    // Seven data bits, two stop bits.
    s7.delete(); d = nd7;
    din7 = 7'h41; wr7 = 1'b1;
    @(negedge clk);
    din7 = 7'h2A;
    @(negedge clk);
    wr7 = 1'b0;
    wait_done(1, d + 2);
    repeat (8) @(negedge clk);
    decode(s7, 7, 2);
    chk("d7_nframes", rx_w.size(), 2);
    if (rx_w.size() == 2) begin
      chk("d7_w0", rx_w[0], 9'h41);
      chk("d7_w1", rx_w[1], 9'h2A);
      chk("d7_gap", rx_g[1], 0);
      if (PE != 0) chk("d7_par0", rx_p[0], 0);
      if (PE != 0) chk("d7_par1", rx_p[1], 1);
    end
    chk("d7_stop_bad", rx_bad, 0);

    // clken held high: one bit per cycle.
    mode = 2;
    repeat (2) @(negedge clk);
    s8.delete(); d = nd8;
    push8(8'h3C);
    wait_done(0, d + 1);
    repeat (4) @(negedge clk);
    decode(s8, 8, 1);
    chk("fast_n", rx_w.size(), 1);
    if (rx_w.size() == 1) chk("fast_w", rx_w[0], 9'h3C);
    chk("fast_bad", rx_bad, 0);
    mode = 1;
    repeat (8) @(negedge clk);

    // Reset in mid-DATA with two words still queued.
    push8(8'hA1); push8(8'hB2); push8(8'hC3);
    j = 0;
    while (tx && j < 500) begin
      @(negedge clk);
      j++;
    end
    chk("rst_saw_start", tx, 0);
    repeat (8) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    s8.delete(); d = nd8;
    repeat (200) @(negedge clk);
    zeros = 0;
    foreach (s8[k]) if (!s8[k]) zeros++;
    chk("post_rst_line", zeros, 0);
    chk("post_rst_done", nd8 - d, 0);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
